game_tick_scheduler: RTL and testbench

- Controls game pacing for the ping-pong design. Divides the system clock into a single-cycle `tick` enable that the ball-motion logic consumes.
- Sequences the rally through serve delay, play, pause and point-reset.
- Shortens the tick period (speeds up the ball) after every group of paddle hits, down to a floor.

---
 rtl/game_tick_scheduler_if.sv | 21 ++
 rtl/game_tick_scheduler.sv | 151 +++++++++++++++
 tb/tb_game_tick_scheduler.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_tick_scheduler_if.sv
// Control/status bundle between the game pacing scheduler and the rest of the
// ping-pong design: event pulses in, tick enable and rally status out.
interface game_tick_scheduler_if;
  logic       start;
  logic       pause_req;
  logic       hit;
  logic       point;
  logic       tick;
  logic [1:0] state;
  logic [3:0] level;

  modport slave (
    input  start, pause_req, hit, point,
    output tick, state, level
  );

  modport master (
    output start, pause_req, hit, point,
    input  tick, state, level
  );
endinterface

// File: rtl/game_tick_scheduler.sv
// Game pacing: divides clk into a single-cycle ball-move tick, sequences the
// rally (idle, serve delay, play, pause) and speeds up after groups of hits.
module game_tick_scheduler #(
  parameter int CNT_W         = 27,
  parameter int BASE_DIV      = 33333333,
  parameter int MIN_DIV       = 8333333,
  parameter int STEP_DIV      = 4166667,
  parameter int HITS_PER_STEP = 4,
  parameter int SERVE_TICKS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  game_tick_scheduler_if.slave  bus
);

  localparam int HC_W = $clog2(HITS_PER_STEP + 1);
  localparam int SC_W = $clog2(SERVE_TICKS + 1);

  localparam logic [CNT_W-1:0] BASE_C     = CNT_W'(BASE_DIV);
  localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] STEP_C     = CNT_W'(STEP_DIV);
  localparam logic [CNT_W:0]   STEP_FLOOR = (CNT_W+1)'(MIN_DIV + STEP_DIV);
  localparam logic [HC_W-1:0]  HIT_LAST   = HC_W'(HITS_PER_STEP - 1);
  localparam logic [SC_W-1:0]  SERVE_LAST = SC_W'(SERVE_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SERVE = 2'b01,
    S_PLAY  = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  state_t           r_state;
  state_t           r_resume_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cur_div;
  logic [HC_W-1:0]  r_hit_cnt;
  logic [SC_W-1:0]  r_serve_cnt;
  logic [3:0]       r_level;
  logic             r_tick;

  logic             w_play_wrap;
  logic             w_serve_wrap;
  logic [CNT_W-1:0] w_next_div;
  logic             w_div_drops;

  // Greater-or-equal so a period that shrinks below the running count still fires.
  assign w_play_wrap  = (r_cnt >= (r_cur_div - CNT_W'(1)));
  assign w_serve_wrap = (r_cnt == (BASE_C - CNT_W'(1)));

  // Compare before subtracting so the period never underflows past the floor.
  always_comb begin
    w_next_div = MIN_C;
    if ({1'b0, r_cur_div} >= STEP_FLOOR) begin
      w_next_div = r_cur_div - STEP_C;
    end
  end

  assign w_div_drops = (w_next_div < r_cur_div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_resume_state <= S_SERVE;
      r_cnt          <= '0;
      r_cur_div      <= BASE_C;
      r_hit_cnt      <= '0;
      r_serve_cnt    <= '0;
      r_level        <= '0;
      r_tick         <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.start) begin
            r_state     <= S_SERVE;
            r_serve_cnt <= '0;
          end
        end

        S_SERVE: begin
          if (bus.pause_req) begin
            r_resume_state <= S_SERVE;
            r_state        <= S_PAUSE;
          end else if (w_serve_wrap) begin
            r_cnt <= '0;
            if (r_serve_cnt == SERVE_LAST) begin
              r_state     <= S_PLAY;
              r_serve_cnt <= '0;
            end else begin
              r_serve_cnt <= r_serve_cnt + SC_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_PLAY: begin
          if (bus.point) begin
            r_state     <= S_SERVE;
            r_cur_div   <= BASE_C;
            r_level     <= '0;
            r_hit_cnt   <= '0;
            r_cnt       <= '0;
            r_serve_cnt <= '0;
          end else if (bus.pause_req) begin
            r_resume_state <= S_PLAY;
            r_state        <= S_PAUSE;
            // A wrap coinciding with the pause still completes and emits its tick.
            if (w_play_wrap) begin
              r_cnt  <= '0;
              r_tick <= 1'b1;
            end
          end else begin
            if (w_play_wrap) begin
              r_cnt  <= '0;
              r_tick <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            if (bus.hit) begin
              if (r_hit_cnt != HIT_LAST) begin
                r_hit_cnt <= r_hit_cnt + HC_W'(1);
              end else begin
                r_hit_cnt <= '0;
                r_cur_div <= w_next_div;
                if (w_div_drops && (r_level != 4'd15)) begin
                  r_level <= r_level + 4'd1;
                end
              end
            end
          end
        end

        S_PAUSE: begin
          if (bus.pause_req) begin
            r_state <= r_resume_state;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tick  = r_tick;
  assign bus.state = r_state;
  assign bus.level = r_level;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench for game_tick_scheduler: a cycle-stamped reference model
// queues expected tick and status events; a monitor matches DUT events to them.
module tb_game_tick_scheduler;

  localparam int BASE_DIV      = 10;
  localparam int MIN_DIV       = 4;
  localparam int STEP_DIV      = 3;
  localparam int HITS_PER_STEP = 2;
  localparam int SERVE_TICKS   = 2;

  logic clk;
  logic rst_n;

  game_tick_scheduler_if bus();

  game_tick_scheduler #(
    .CNT_W        (27),
    .BASE_DIV     (BASE_DIV),
    .MIN_DIV      (MIN_DIV),
    .STEP_DIV     (STEP_DIV),
    .HITS_PER_STEP(HITS_PER_STEP),
    .SERVE_TICKS  (SERVE_TICKS)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    int st;
    int lv;
  } stat_t;

  int    tick_q[$];
  stat_t stat_q[$];

  int cyc = 0;
  int m_st, m_resume, m_serve, m_phase, m_div, m_hits, m_lvl;
  int p_st, p_lv;
  bit m_tick;

  task automatic model_reset();
    m_st = 0; m_resume = 1; m_serve = 0; m_phase = 0;
    m_div = BASE_DIV; m_hits = 0; m_lvl = 0;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    p_st = m_st;
    p_lv = m_lvl;
    m_tick = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      cyc++;
      case (m_st)
        0: if (bus.start) begin m_st = 1; m_serve = 0; m_phase = 0; end
        1: begin
          if (bus.pause_req) begin
            m_resume = 1; m_st = 3;
          end else begin
            // serve time counted as total elapsed serve cycles
            m_serve++;
            if (m_serve == SERVE_TICKS * BASE_DIV) begin
              m_st = 2; m_phase = 0; m_serve = 0;
            end
          end
        end
        2: begin
          if (bus.point) begin
            m_st = 1; m_serve = 0; m_phase = 0;
            m_div = BASE_DIV; m_lvl = 0; m_hits = 0;
          end else if (bus.pause_req) begin
            m_resume = 2; m_st = 3;
            if (m_phase + 1 >= m_div) begin m_phase = 0; m_tick = 1'b1; end
          end else begin
            if (m_phase + 1 >= m_div) begin m_phase = 0; m_tick = 1'b1; end
            else m_phase++;
            if (bus.hit) begin
              m_hits++;
              if (m_hits == HITS_PER_STEP) begin
                int nd;
                m_hits = 0;
                nd = m_div - STEP_DIV;
                if (nd < MIN_DIV) nd = MIN_DIV;
                if (nd < m_div && m_lvl < 15) m_lvl++;
                m_div = nd;
              end
            end
          end
        end
        default: if (bus.pause_req) m_st = m_resume;
      endcase
    end
    if (m_tick) tick_q.push_back(cyc);
    if (m_st != p_st || m_lvl != p_lv) stat_q.push_back('{cyc: cyc, st: m_st, lv: m_lvl});
  end

  // ---------------- monitor ----------------
  logic [1:0] prev_st = 2'b00;
  logic [3:0] prev_lv = 4'd0;

  always @(posedge clk or negedge rst_n) begin
    #1;
    if (bus.tick === 1'b1) begin
      if (tick_q.size() == 0) check("tick_unexpected", cyc, -1);
      else check("tick_cycle", cyc, tick_q.pop_front());
    end
    if (bus.state !== prev_st || bus.level !== prev_lv) begin
      if (stat_q.size() == 0) begin
        check("status_unexpected", int'({bus.state, bus.level}), -1);
      end else begin
        stat_t e;
        e = stat_q.pop_front();
        check("status_cycle", cyc, e.cyc);
        check("status_state", int'(bus.state), e.st);
        check("status_level", int'(bus.level), e.lv);
      end
      prev_st = bus.state;
      prev_lv = bus.level;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input bit s, input bit pr, input bit h, input bit p);
    bus.start = s; bus.pause_req = pr; bus.hit = h; bus.point = p;
    @(negedge clk);
    bus.start = 1'b0; bus.pause_req = 1'b0; bus.hit = 1'b0; bus.point = 1'b0;
  endtask

  task automatic wait_tick(output int k);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (bus.tick !== 1'b1 && k < 200);
  endtask

  task automatic wait_state(input logic [1:0] s, output int k);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (bus.state !== s && k < 200);
  endtask

  task automatic wait_model_phase(input int ph);
    int n;
    n = 0;
    while (!(m_st == 2 && m_phase == ph) && n < 200) begin
      @(negedge clk); n++;
    end
    check("model_phase_reached", n < 200, 1);
  endtask

  initial begin
    int k, n;
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    bus.start = 0; bus.pause_req = 0; bus.hit = 0; bus.point = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_state", int'(bus.state), 0);
    check("reset_tick", int'(bus.tick), 0);
    check("reset_level", int'(bus.level), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: serve length, first tick, base spacing
    pulse(1, 0, 0, 0);
    wait_state(2'b01, k);
    wait_state(2'b10, k);
    check("serve_cycles", k + 1, SERVE_TICKS * BASE_DIV);
    wait_tick(k); check("first_tick_gap", k, BASE_DIV);
    wait_tick(k); check("base_spacing", k, BASE_DIV);

    // 2: speed steps down to the floor
    @(negedge clk);
    pulse(0, 0, 1, 0); repeat (2) @(negedge clk); pulse(0, 0, 1, 0);
    repeat (25) @(negedge clk);
    check("level_after_2_hits", int'(bus.level), 1);
    wait_tick(k); wait_tick(k); check("spacing_level1", k, 7);
    @(negedge clk);
    pulse(0, 0, 1, 0); pulse(0, 0, 1, 0);
    repeat (20) @(negedge clk);
    check("level_after_4_hits", int'(bus.level), 2);
    wait_tick(k); wait_tick(k); check("spacing_level2", k, 4);
    @(negedge clk);
    pulse(0, 0, 1, 0); repeat (3) @(negedge clk); pulse(0, 0, 1, 0);
    repeat (20) @(negedge clk);
    check("level_at_floor", int'(bus.level), 2);
    wait_tick(k); wait_tick(k); check("spacing_floor", k, 4);

    // 4: point beats hit in the same cycle
    @(negedge clk);
    pulse(0, 0, 1, 1);
    check("point_state", int'(bus.state), 1);
    check("point_level", int'(bus.level), 0);
    wait_state(2'b10, k);
    wait_tick(k); wait_tick(k); check("spacing_after_point", k, BASE_DIV);

    // 3: pause mid-period freezes the count
    @(negedge clk);
    wait_model_phase(5);
    pulse(0, 1, 0, 0);
    n = 0;
    repeat (30) begin @(posedge clk); #1; if (bus.tick === 1'b1) n++; end
    check("ticks_in_pause", n, 0);
    check("paused_state", int'(bus.state), 3);
    @(negedge clk);
    pulse(0, 1, 0, 0);
    check("resumed_state", int'(bus.state), 2);
    wait_tick(k); check("tick_after_resume", k, 5);

    // pause on the wrap cycle still emits the tick
    @(negedge clk);
    wait_model_phase(BASE_DIV - 1);
    pulse(0, 1, 0, 0);
    check("wrap_pause_tick", int'(bus.tick), 1);
    check("wrap_pause_state", int'(bus.state), 3);
    repeat (5) @(negedge clk);
    pulse(0, 1, 0, 0);
    repeat (3) @(negedge clk);

    // 6: pause during serve at serve cycle 12
    wait_model_phase(0);
    pulse(0, 0, 0, 1);
    repeat (12) @(negedge clk);
    pulse(0, 1, 0, 0);
    repeat (8) @(negedge clk);
    check("serve_paused", int'(bus.state), 3);
    pulse(0, 1, 0, 0);
    wait_state(2'b10, k);
    check("serve_after_resume", k, 8);

    // 5: asynchronous reset mid-play, IDLE ignores other events
    @(negedge clk);
    pulse(0, 0, 1, 0); pulse(0, 0, 1, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_state", int'(bus.state), 0);
    check("async_reset_level", int'(bus.level), 0);
    check("async_reset_tick", int'(bus.tick), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse(0, 0, 1, 0); pulse(0, 1, 0, 0); pulse(0, 0, 0, 1);
    repeat (5) @(negedge clk);
    check("idle_ignores_state", int'(bus.state), 0);
    pulse(1, 0, 0, 0);
    check("restart_state", int'(bus.state), 1);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      bus.start     = ($urandom_range(99) < 2);
      bus.pause_req = ($urandom_range(99) < 3);
      bus.hit       = ($urandom_range(99) < 15);
      bus.point     = ($urandom_range(199) < 1);
      @(negedge clk);
    end
    bus.start = 0; bus.pause_req = 0; bus.hit = 0; bus.point = 0;
    repeat (4) @(negedge clk);

    check("tick_queue_drained", tick_q.size(), 0);
    check("status_queue_drained", stat_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
